fp_unit_arbiter: RTL

- Shares one fixed-latency pipelined FP arithmetic block (a wrapper instance from arithmetic_block_wrappers, e.g. the multiplier) between N_REQ independent ready/valid requesters.
- Arbitrates issue slots round-robin and tags every issued operation.
- Steers each result back to the issuing requester through a per-requester response FIFO.
- Uses credits so the unit, which has no backpressure, can never overflow a stalled response FIFO.
- Sits between formula datapaths like the challenge pipeline and a single shared multiplier or adder to save arithmetic blocks.

---
 rtl/fp_arb_pkg.sv | 19 +
 rtl/fp_arb_rsp_fifo.sv | 59 +++++
 rtl/fp_unit_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared types and widths for the FP unit arbiter
package fp_arb_pkg;

    // Requester ids are sized for the largest supported requester count
    localparam int MAX_N_REQ = 8;
    localparam int REQ_ID_W  = $clog2(MAX_N_REQ);

    typedef logic [REQ_ID_W-1:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } tag_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fp_arb_rsp_fifo.sv
// rtl/fp_arb_rsp_fifo.sv - flop-based response FIFO with occupancy count
module fp_arb_rsp_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 6,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);
    import fp_arb_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
            if (do_wr && !do_rd) begin
                count <= count + CNT_W'(1);
            end else if (do_rd && !do_wr) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// rtl/fp_unit_arbiter.sv - round-robin, credit-guarded sharing of one pipelined FP unit
module fp_unit_arbiter #(
    parameter int FLEN       = 64,
    parameter int N_REQ      = 2,
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    output logic [N_REQ-1:0]           req_rdy,
    input  logic [N_REQ-1:0][FLEN-1:0] req_a,
    input  logic [N_REQ-1:0][FLEN-1:0] req_b,
    output logic [N_REQ-1:0]           rsp_vld,
    input  logic [N_REQ-1:0]           rsp_rdy,
    output logic [N_REQ-1:0][FLEN-1:0] rsp_res,
    output logic                       unit_up_vld,
    output logic [FLEN-1:0]            unit_a,
    output logic [FLEN-1:0]            unit_b,
    input  logic                       unit_down_vld,
    input  logic [FLEN-1:0]            unit_res,
    output logic                       err
);
    import fp_arb_pkg::*;

    localparam int CNT_W = cnt_width(FIFO_DEPTH);

    req_id_t          ptr;
    req_id_t          gid;
    logic             hs_any;
    logic [N_REQ-1:0] credit_ok;
    logic [N_REQ-1:0] hs;
    logic [N_REQ-1:0] fifo_wr;
    logic [N_REQ-1:0] fifo_rd;
    logic [N_REQ-1:0] fifo_empty;
    logic [N_REQ-1:0] fifo_full;
    logic [CNT_W-1:0] fifo_cnt [N_REQ];
    tag_t             tag_pipe [LATENCY];
    tag_t             tail;

    // Credit is whatever the FIFO could still absorb once every in-flight tag lands
    always_comb begin
        int used;
        used = 0;
        for (int i = 0; i < N_REQ; i++) begin
            used = int'(fifo_cnt[i]);
            for (int k = 0; k < LATENCY; k++) begin
                if (tag_pipe[k].vld && (tag_pipe[k].id == req_id_t'(i))) begin
                    used = used + 1;
                end
            end
            credit_ok[i] = (used < FIFO_DEPTH);
        end
    end

    // Ready ignores the requester's own valid so it can be used as an offer
    always_comb begin
        int   j;
        logic blocked;
        logic reached;
        j = 0;
        blocked = 1'b0;
        reached = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            blocked = 1'b0;
            reached = 1'b0;
            for (int k = 0; k < N_REQ; k++) begin
                j = (int'(ptr) + k) % N_REQ;
                if (j == i) begin
                    reached = 1'b1;
                end else if (!reached && req_vld[j] && credit_ok[j]) begin
                    blocked = 1'b1;
                end
            end
            req_rdy[i] = credit_ok[i] && !blocked;
        end
    end

    assign hs = req_vld & req_rdy;

    always_comb begin
        gid    = '0;
        hs_any = 1'b0;
        unit_a = '0;
        unit_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (hs[i]) begin
                gid    = req_id_t'(i);
                hs_any = 1'b1;
                unit_a = req_a[i];
                unit_b = req_b[i];
            end
        end
    end

    assign unit_up_vld = hs_any;
    assign tail        = tag_pipe[LATENCY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_pipe[k] <= '0;
            end
        end else begin
            if (hs_any) begin
                ptr <= (gid == req_id_t'(N_REQ - 1)) ? '0 : gid + req_id_t'(1);
            end
            tag_pipe[0] <= '{vld: hs_any, id: gid};
            for (int k = 1; k < LATENCY; k++) begin
                tag_pipe[k] <= tag_pipe[k-1];
            end
        end
    end

    // A result without a matching tag (or a tag without a result) is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((tail.vld != unit_down_vld) || (|(fifo_wr & fifo_full))) begin
            err <= 1'b1;
        end
    end

    assign rsp_vld = ~fifo_empty;
    assign fifo_rd = rsp_vld & rsp_rdy;

    for (genvar i = 0; i < N_REQ; i++) begin : g_rsp
        assign fifo_wr[i] = tail.vld && unit_down_vld && (tail.id == req_id_t'(i));

        fp_arb_rsp_fifo #(
            .WIDTH (FLEN),
            .DEPTH (FIFO_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (fifo_wr[i]),
            .wr_data (unit_res),
            .rd_en   (fifo_rd[i]),
            .rd_data (rsp_res[i]),
            .empty   (fifo_empty[i]),
            .full    (fifo_full[i]),
            .count   (fifo_cnt[i])
        );
    end

endmodule
